rename_fl: RTL and testbench
============================

// Module: rename_fl
// PURPOSE
//  Next-gen rename stage: maps arch regs (rs1/rs2/rd) to physical regs via a speculative map (SRMT) backed by
//  a circular free list, so pregs are recycled by retirement instead of a wrapping counter. Keeps a committed
//  map (CRMT) and committed free-list head so a flush restores precise rename state in one cycle.
//  Sits between decode and dispatch/ROB; retire port driven by the ROB commit stage.
// PARAMETERS
//  ARFSIZE  32  architectural registers; AW = $clog2(ARFSIZE)
//  PRFSIZE  64  physical registers, power of 2; PW = $clog2(PRFSIZE)
//  ZERO_REG  1  1: areg 0 is never renamed (rd=0 allocates nothing, rs=0 reads renamed=0)
// PORTS
//  clk                   in   1        clock
//  rstn                  in   1        asynchronous active-low reset
//  flush_i               in   1        1-cycle pulse: squash all un-retired renames
//  di_i                  in   di_t     decoded instr (si.rs1/rs2/rd, *_valid, id, fault, valid)
//  di_i_valid            in   1        input valid
//  di_i_ready            out  1        input accepted when valid&&ready
//  di_o                  out  di_t     renamed instr: prs1/2, prs1/2_renammed, prd, prd_old, prd_old_valid
//  di_o_valid            out  1        output register valid
//  di_o_ready            in   1        downstream ready
//  retire_entry_i        in   rob_entry_t  retiring entry (rd, prd, prd_old, prd_old_valid, needprf2arf)
//  retire_entry_i_valid  in   1        retire strobe, in program order
//  free_count_o          out  PW+1     free pregs (debug/perf)
// BEHAVIOUR
//  Reset (async, rstn=0): SRMT/CRMT valid bits all 0; free list entry i = i; head=chead=0, tail=PRFSIZE
//   (PW+1-bit ptrs, wrap bit); free_count_o=PRFSIZE; di_o_valid=0; di_o=0. Reset mid-op drops all state.
//  Accept: fire = di_i_valid && di_i_ready. di_i_ready = !flush_i && (!di_o_valid || di_o_ready) && !stall.
//  stall = di_i_valid && need_alloc && (free_count==0); need_alloc = si.rd_valid && !(ZERO_REG && rd==0).
//  Latency 1: on fire, di_o <= renamed di_i, di_o_valid <= 1; else if di_o_ready, di_o_valid <= 0.
//  Read: prsN = SRMT[rsN].preg, prsN_renammed = SRMT[rsN].valid && rsN_valid && !(ZERO_REG && rsN==0);
//   SRMT read is pre-update value; back-to-back dependents see the update from the previous accept (no bypass needed).
//  Alloc (fire && need_alloc): prd = fl[head]; head++; prd_old/prd_old_valid = SRMT[rd] pre-write;
//   SRMT[rd] <= {1,prd}. Same-instr rs==rd reads the old mapping. No alloc: prd=0, prd_old_valid=0.
//  Retire (retire_entry_i_valid && needprf2arf): CRMT[rd] <= {1,prd}; chead++;
//   if prd_old_valid: fl[tail] <= prd_old, tail++ (freed preg becomes allocatable next cycle, no same-cycle bypass).
//  free_count = tail - head (PW+1 modulo). Alloc+free same cycle: count unchanged. count never > PRFSIZE
//   (assert); alloc at count==0 never happens (stall), even if a free arrives that cycle.
//  Flush (priority over accept): SRMT <= CRMT_next (CRMT after same-cycle retire); head <= chead_next;
//   tail unaffected; di_o_valid <= 0; di_i_ready=0 that cycle.
//  Pointer wrap: index = ptr[PW-1:0]; wrap bit disambiguates full/empty.
//  Assertions: retire prd == fl entry at chead; no double free (scoreboard in TB).
// STRUCTURE
//  Package C: add prd_old, prd_old_valid to di_t and rob_entry_t; add rmt_entry_t {valid, preg_id_t};
//   fl_ptr_t = logic [PREG_ID_BITS:0].
//  Sub-module free_list (PRFSIZE entries; pop/push/restore ports; outputs head entry and count).
//  SRMT/CRMT as rmt_entry_t arrays inside rename_fl.
// TESTING
//  Reset, rename 3 instrs rd=5,6,5 rs1=5 -> prd=0,1,2; 3rd prs1=%0 renamed; prd_old=0 valid; free_count=61.
//  64 rd-writing instrs, no retire -> 65th stalls (di_i_ready=0, free_count=0); retire one with prd_old=3 -> next cycle alloc returns 3.
//  Same cycle alloc + retire-free -> free_count unchanged; freed preg not issued that cycle.
//  Rename 4 (prd 0..3), retire first 2, flush -> SRMT==CRMT, head=2, next alloc prd=2, di_o_valid=0.
//  di_o_ready=0 for 5 cycles -> di_o held stable, di_i_ready=0, no extra allocs; rd=0 / rs=0 -> no alloc, renamed=0.
//  Assert rstn mid-stream with di_o_valid=1 -> di_o_valid=0 immediately, free_count=64 after release.

Source files
------------

// File: rtl/rename_fl_pkg.sv
// rename_fl_pkg: shared types and sizes for the rename stage
package rename_fl_pkg;
    localparam int ARFSIZE = 32;
    localparam int PRFSIZE = 64;
    localparam int AW = $clog2(ARFSIZE);
    localparam int PW = $clog2(PRFSIZE);
    localparam bit ZERO_REG = 1'b1;
    localparam int ID_BITS = 8;

    typedef logic [AW-1:0] areg_id_t;
    typedef logic [PW-1:0] preg_id_t;
    typedef logic [PW:0] fl_ptr_t;

    localparam fl_ptr_t FL_FULL = fl_ptr_t'(PRFSIZE);

    typedef struct packed {
        areg_id_t rs1;
        areg_id_t rs2;
        areg_id_t rd;
        logic     rs1_valid;
        logic     rs2_valid;
        logic     rd_valid;
    } si_t;

    typedef struct packed {
        si_t                si;
        logic [ID_BITS-1:0] id;
        logic               fault;
        logic               valid;
        preg_id_t           prs1;
        preg_id_t           prs2;
        logic               prs1_renammed;
        logic               prs2_renammed;
        preg_id_t           prd;
        preg_id_t           prd_old;
        logic               prd_old_valid;
    } di_t;

    typedef struct packed {
        areg_id_t rd;
        preg_id_t prd;
        preg_id_t prd_old;
        logic     prd_old_valid;
        logic     needprf2arf;
    } rob_entry_t;

    typedef struct packed {
        logic     valid;
        preg_id_t preg;
    } rmt_entry_t;

    // areg 0 is hardwired and never takes part in renaming
    function automatic logic is_zero(areg_id_t a);
        return ZERO_REG && (a == '0);
    endfunction
endpackage

// File: rtl/rename_fl_free_list.sv
// rename_fl_free_list: circular free list of pregs with speculative and committed heads
module rename_fl_free_list
    import rename_fl_pkg::*;
(
    input  logic     clk,
    input  logic     rstn,
    input  logic     pop_i,
    input  logic     push_i,
    input  preg_id_t push_preg_i,
    input  logic     commit_i,
    input  preg_id_t commit_preg_i,
    input  logic     restore_i,
    output preg_id_t head_preg_o,
    output fl_ptr_t  count_o
);
    preg_id_t fl_q [PRFSIZE];
    fl_ptr_t  head_q, head_d, tail_q, tail_d, chead_q, chead_d;

    assign head_preg_o = fl_q[head_q[PW-1:0]];
    assign count_o     = tail_q - head_q;

    // Pointer next state; a restore rewinds head to the committed head including this cycle's retire
    always_comb begin
        chead_d = chead_q + fl_ptr_t'(commit_i);
        tail_d  = tail_q + fl_ptr_t'(push_i);
        head_d  = restore_i ? chead_d : head_q + fl_ptr_t'(pop_i);
    end

    // List storage and pointers; freed pregs land at the tail
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PRFSIZE; i++) fl_q[i] <= preg_id_t'(i);
            head_q  <= '0;
            chead_q <= '0;
            tail_q  <= FL_FULL;
        end else begin
            if (push_i) fl_q[tail_q[PW-1:0]] <= push_preg_i;
            head_q  <= head_d;
            chead_q <= chead_d;
            tail_q  <= tail_d;
        end
    end

    // Invariants: never more than PRFSIZE free, retirement consumes the list in allocation order
    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (count_o <= FL_FULL);
            if (commit_i) assert (fl_q[chead_q[PW-1:0]] == commit_preg_i);
        end
    end
endmodule

// File: rtl/rename_fl.sv
// rename_fl: rename stage with speculative/committed maps and a recycling free list
module rename_fl
    import rename_fl_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush_i,
    input  di_t        di_i,
    input  logic       di_i_valid,
    output logic       di_i_ready,
    output di_t        di_o,
    output logic       di_o_valid,
    input  logic       di_o_ready,
    input  rob_entry_t retire_entry_i,
    input  logic       retire_entry_i_valid,
    output fl_ptr_t    free_count_o
);
    rmt_entry_t srmt_q [ARFSIZE];
    rmt_entry_t srmt_d [ARFSIZE];
    rmt_entry_t crmt_q [ARFSIZE];
    rmt_entry_t crmt_d [ARFSIZE];
    di_t        di_o_q, di_o_d;
    logic       di_o_valid_q;
    logic       need_alloc, stall, fire, alloc, commit, push;
    preg_id_t   head_preg;
    fl_ptr_t    count;

    rename_fl_free_list u_fl (
        .clk          (clk),
        .rstn         (rstn),
        .pop_i        (alloc),
        .push_i       (push),
        .push_preg_i  (retire_entry_i.prd_old),
        .commit_i     (commit),
        .commit_preg_i(retire_entry_i.prd),
        .restore_i    (flush_i),
        .head_preg_o  (head_preg),
        .count_o      (count)
    );

    assign di_o         = di_o_q;
    assign di_o_valid   = di_o_valid_q;
    assign free_count_o = count;

    // Handshake: stall only when this instr needs a preg and none is free right now
    always_comb begin
        need_alloc = di_i.si.rd_valid && !is_zero(di_i.si.rd);
        stall      = di_i_valid && need_alloc && (count == '0);
        di_i_ready = !flush_i && (!di_o_valid_q || di_o_ready) && !stall;
        fire       = di_i_valid && di_i_ready;
        alloc      = fire && need_alloc;
        commit     = retire_entry_i_valid && retire_entry_i.needprf2arf;
        push       = commit && retire_entry_i.prd_old_valid;
    end

    // Rename from the pre-update speculative map, so rs==rd sees the previous mapping
    always_comb begin
        di_o_d               = di_i;
        di_o_d.prs1          = srmt_q[di_i.si.rs1].preg;
        di_o_d.prs2          = srmt_q[di_i.si.rs2].preg;
        di_o_d.prs1_renammed = srmt_q[di_i.si.rs1].valid && di_i.si.rs1_valid && !is_zero(di_i.si.rs1);
        di_o_d.prs2_renammed = srmt_q[di_i.si.rs2].valid && di_i.si.rs2_valid && !is_zero(di_i.si.rs2);
        di_o_d.prd           = need_alloc ? head_preg : '0;
        di_o_d.prd_old       = need_alloc ? srmt_q[di_i.si.rd].preg : '0;
        di_o_d.prd_old_valid = need_alloc && srmt_q[di_i.si.rd].valid;
    end

    // Map next state: retire updates the committed map; flush copies it (with this retire) into the speculative one
    always_comb begin
        crmt_d = crmt_q;
        if (commit) crmt_d[retire_entry_i.rd] = '{valid: 1'b1, preg: retire_entry_i.prd};
        srmt_d = srmt_q;
        if (flush_i) srmt_d = crmt_d;
        else if (alloc) srmt_d[di_i.si.rd] = '{valid: 1'b1, preg: head_preg};
    end

    // Maps and the output register; flush squashes the instruction held at the output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ARFSIZE; i++) begin
                srmt_q[i] <= '0;
                crmt_q[i] <= '0;
            end
            di_o_q       <= '0;
            di_o_valid_q <= 1'b0;
        end else begin
            srmt_q       <= srmt_d;
            crmt_q       <= crmt_d;
            if (fire) di_o_q <= di_o_d;
            di_o_valid_q <= !flush_i && (fire || (di_o_valid_q && !di_o_ready));
        end
    end
endmodule

// File: tb/tb_rename_fl.sv
// tb_rename_fl: directed and randomized checks of rename_fl against a map/queue reference model
module tb_rename_fl;
    import rename_fl_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       flush_i, di_i_valid, di_i_ready, di_o_valid, di_o_ready, retire_entry_i_valid;
    di_t        di_i, di_o;
    rob_entry_t retire_entry_i;
    fl_ptr_t    free_count_o;
    int         errors = 0;
    int         checks = 0;

    rename_fl dut (
        .clk                 (clk),
        .rstn                (rstn),
        .flush_i             (flush_i),
        .di_i                (di_i),
        .di_i_valid          (di_i_valid),
        .di_i_ready          (di_i_ready),
        .di_o                (di_o),
        .di_o_valid          (di_o_valid),
        .di_o_ready          (di_o_ready),
        .retire_entry_i      (retire_entry_i),
        .retire_entry_i_valid(retire_entry_i_valid),
        .free_count_o        (free_count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // reference model: arch->preg maps, free pregs in allocation order, in-flight renames in program order
    logic       m_v [ARFSIZE];
    preg_id_t   m_p [ARFSIZE];
    logic       c_v [ARFSIZE];
    preg_id_t   c_p [ARFSIZE];
    int         fq[$];
    rob_entry_t rob[$];
    di_t        exp_do;
    logic       exp_ov;

    function automatic logic need(di_t d);
        return d.si.rd_valid && !(ZERO_REG && d.si.rd == '0);
    endfunction

    function automatic logic exp_ready();
        return !flush_i && (!exp_ov || di_o_ready) && !(di_i_valid && need(di_i) && fq.size() == 0);
    endfunction

    function automatic int rdseq(int i);
        return i < 4 ? i + 1 : 4 - (i - 4) % 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ARFSIZE; i++) begin
            m_v[i] = 1'b0; m_p[i] = '0; c_v[i] = 1'b0; c_p[i] = '0;
        end
        fq.delete();
        for (int i = 0; i < PRFSIZE; i++) fq.push_back(i);
        rob.delete();
        exp_do = '0;
        exp_ov = 1'b0;
    endtask

    // advance one clock, updating the model from the stimulus currently applied
    task automatic cycle();
        logic       fire;
        di_t        r;
        rob_entry_t e;
        areg_id_t   a;
        fire = di_i_valid && exp_ready();
        @(posedge clk);
        if (fire) begin
            r = di_i;
            r.prs1 = m_p[di_i.si.rs1];
            r.prs2 = m_p[di_i.si.rs2];
            r.prs1_renammed = m_v[di_i.si.rs1] && di_i.si.rs1_valid && di_i.si.rs1 != '0;
            r.prs2_renammed = m_v[di_i.si.rs2] && di_i.si.rs2_valid && di_i.si.rs2 != '0;
            r.prd = '0; r.prd_old = '0; r.prd_old_valid = 1'b0;
            if (need(di_i)) begin
                a = di_i.si.rd;
                r.prd = preg_id_t'(fq.pop_front());
                r.prd_old = m_p[a];
                r.prd_old_valid = m_v[a];
                m_v[a] = 1'b1; m_p[a] = r.prd;
                e.rd = a; e.prd = r.prd; e.prd_old = r.prd_old;
                e.prd_old_valid = r.prd_old_valid; e.needprf2arf = 1'b1;
                rob.push_back(e);
            end
            exp_do = r;
            exp_ov = 1'b1;
        end else if (di_o_ready) exp_ov = 1'b0;
        if (retire_entry_i_valid && retire_entry_i.needprf2arf) begin
            c_v[retire_entry_i.rd] = 1'b1;
            c_p[retire_entry_i.rd] = retire_entry_i.prd;
            if (retire_entry_i.prd_old_valid) fq.push_back(int'(retire_entry_i.prd_old));
            void'(rob.pop_front());
        end
        if (flush_i) begin
            for (int i = rob.size() - 1; i >= 0; i--) fq.push_front(int'(rob[i].prd));
            rob.delete();
            for (int i = 0; i < ARFSIZE; i++) begin
                m_v[i] = c_v[i]; m_p[i] = c_p[i];
            end
            exp_ov = 1'b0;
        end
        #1;
    endtask

    task automatic drive(input logic v, input int rd, input int rs1, input int rs2, input logic rdv);
        di_i = '0;
        di_i.si.rd = areg_id_t'(rd);
        di_i.si.rs1 = areg_id_t'(rs1);
        di_i.si.rs2 = areg_id_t'(rs2);
        di_i.si.rd_valid = rdv;
        di_i.si.rs1_valid = 1'b1;
        di_i.si.rs2_valid = 1'b1;
        di_i.id = ID_BITS'($urandom);
        di_i.fault = 1'($urandom);
        di_i.valid = 1'b1;
        di_i_valid = v;
    endtask

    task automatic ret_front();
        retire_entry_i = rob[0];
        retire_entry_i_valid = 1'b1;
    endtask

    task automatic ret_none();
        retire_entry_i = '0;
        retire_entry_i_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        flush_i = 1'b0;
        di_i = '0;
        di_i_valid = 1'b0;
        di_o_ready = 1'b1;
        ret_none();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (di_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", di_o_valid); end
        checks++; if (di_o !== '0) begin errors++; $display("FAIL reset_di_o: got %h expected 0", di_o); end
        checks++; if (free_count_o !== FL_FULL) begin errors++; $display("FAIL reset_count: got %0d expected 64", free_count_o); end
        checks++; if (di_i_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", di_i_ready); end
    endtask

    task automatic test_basic();
        drive(1'b1, 5, 5, 0, 1'b1);
        cycle();
        checks++; if (di_o.prd !== preg_id_t'(0) || di_o.prs1_renammed !== 1'b0 || di_o.prd_old_valid !== 1'b0) begin
            errors++; $display("FAIL basic_first: got prd=%0d ren=%b pov=%b expected 0 0 0", di_o.prd, di_o.prs1_renammed, di_o.prd_old_valid); end
        drive(1'b1, 6, 5, 0, 1'b1);
        cycle();
        checks++; if (di_o.prd !== preg_id_t'(1) || di_o.prs1 !== preg_id_t'(0) || di_o.prs1_renammed !== 1'b1) begin
            errors++; $display("FAIL basic_second: got prd=%0d prs1=%0d ren=%b expected 1 0 1", di_o.prd, di_o.prs1, di_o.prs1_renammed); end
        drive(1'b1, 5, 5, 0, 1'b1);
        cycle();
        checks++; if (di_o.prd !== preg_id_t'(2) || di_o.prs1 !== preg_id_t'(0) || di_o.prs1_renammed !== 1'b1
                      || di_o.prd_old !== preg_id_t'(0) || di_o.prd_old_valid !== 1'b1) begin
            errors++; $display("FAIL basic_third: got %h expected prd=2 prs1=0 renamed prd_old=0 valid", di_o); end
        checks++; if (di_o !== exp_do) begin errors++; $display("FAIL basic_model: got %h expected %h", di_o, exp_do); end
        di_i_valid = 1'b0;
        checks++; if (free_count_o !== fl_ptr_t'(61)) begin errors++; $display("FAIL basic_count: got %0d expected 61", free_count_o); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, rdseq(i), rdseq(i), 0, 1'b1);
            cycle();
            checks++; if (di_o_valid !== 1'b1 || di_o.prd !== preg_id_t'(i)) begin
                errors++; $display("FAIL fill_prd: got valid=%b prd=%0d expected 1 %0d", di_o_valid, di_o.prd, i); end
        end
        drive(1'b1, 7, 4, 0, 1'b1);
        #1;
        checks++; if (di_i_ready !== 1'b0 || free_count_o !== '0) begin
            errors++; $display("FAIL stall_65th: got ready=%b count=%0d expected 0 0", di_i_ready, free_count_o); end
        cycle();
        checks++; if (di_o_valid !== 1'b0) begin errors++; $display("FAIL stall_no_out: got %b expected 0", di_o_valid); end
        for (int k = 0; k < 4; k++) begin
            ret_front();
            cycle();
        end
        ret_front();
        #1;
        checks++; if (di_i_ready !== 1'b0) begin errors++; $display("FAIL stall_free_same_cycle: got ready=%b expected 0", di_i_ready); end
        cycle();
        ret_none();
        #1;
        checks++; if (di_i_ready !== 1'b1 || free_count_o !== fl_ptr_t'(1)) begin
            errors++; $display("FAIL stall_release: got ready=%b count=%0d expected 1 1", di_i_ready, free_count_o); end
        cycle();
        checks++; if (di_o_valid !== 1'b1 || di_o.prd !== preg_id_t'(3) || free_count_o !== '0) begin
            errors++; $display("FAIL stall_recycled: got valid=%b prd=%0d count=%0d expected 1 3 0", di_o_valid, di_o.prd, free_count_o); end
    endtask

    task automatic test_same_cycle();
        di_i_valid = 1'b0;
        ret_front();
        cycle();
        ret_none();
        checks++; if (free_count_o !== fl_ptr_t'(1)) begin errors++; $display("FAIL same_pre_count: got %0d expected 1", free_count_o); end
        drive(1'b1, 9, 1, 0, 1'b1);
        ret_front();
        #1;
        checks++; if (di_i_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", di_i_ready); end
        cycle();
        ret_none();
        checks++; if (free_count_o !== fl_ptr_t'(1) || di_o.prd !== preg_id_t'(2)) begin
            errors++; $display("FAIL same_alloc_free: got count=%0d prd=%0d expected 1 2", free_count_o, di_o.prd); end
        drive(1'b1, 10, 9, 0, 1'b1);
        cycle();
        checks++; if (di_o.prd !== preg_id_t'(1) || di_o.prs1 !== preg_id_t'(2) || di_o.prs1_renammed !== 1'b1) begin
            errors++; $display("FAIL same_next_alloc: got prd=%0d prs1=%0d ren=%b expected 1 2 1", di_o.prd, di_o.prs1, di_o.prs1_renammed); end
        checks++; if (di_o !== exp_do) begin errors++; $display("FAIL same_model: got %h expected %h", di_o, exp_do); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i + 1, 0, 0, 1'b1);
            if (i == 2) ret_front(); else ret_none();
            cycle();
        end
        drive(1'b1, 9, 3, 1, 1'b1);
        ret_front();
        flush_i = 1'b1;
        di_o_ready = 1'b0;
        #1;
        checks++; if (di_i_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", di_i_ready); end
        cycle();
        flush_i = 1'b0;
        di_o_ready = 1'b1;
        ret_none();
        checks++; if (di_o_valid !== 1'b0 || free_count_o !== fl_ptr_t'(62)) begin
            errors++; $display("FAIL flush_state: got valid=%b count=%0d expected 0 62", di_o_valid, free_count_o); end
        drive(1'b1, 8, 3, 1, 1'b1);
        cycle();
        checks++; if (di_o.prd !== preg_id_t'(2) || di_o.prs1_renammed !== 1'b0 || di_o.prs2_renammed !== 1'b1 || di_o.prs2 !== preg_id_t'(0)) begin
            errors++; $display("FAIL flush_realloc: got %h expected prd=2 rs1 unrenamed rs2=p0", di_o); end
        drive(1'b1, 7, 2, 4, 1'b1);
        cycle();
        checks++; if (di_o.prd !== preg_id_t'(3) || di_o.prs1 !== preg_id_t'(1) || di_o.prs1_renammed !== 1'b1 || di_o.prs2_renammed !== 1'b0) begin
            errors++; $display("FAIL flush_crmt_next: got %h expected prd=3 prs1=p1 rs2 unrenamed", di_o); end
        checks++; if (di_o !== exp_do) begin errors++; $display("FAIL flush_model: got %h expected %h", di_o, exp_do); end
    endtask

    task automatic test_backpressure();
        di_t     held;
        fl_ptr_t cnt;
        drive(1'b1, 10, 2, 0, 1'b1);
        cycle();
        di_o_ready = 1'b0;
        held = di_o;
        cnt = free_count_o;
        drive(1'b1, 11, 10, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (di_i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", di_i_ready); end
            cycle();
            checks++; if (di_o_valid !== 1'b1 || di_o !== held || free_count_o !== cnt) begin
                errors++; $display("FAIL bp_hold: got valid=%b di_o=%h count=%0d expected 1 %h %0d", di_o_valid, di_o, free_count_o, held, cnt); end
        end
        di_o_ready = 1'b1;
        cycle();
        checks++; if (di_o !== exp_do || di_o.prs1 !== held.prd) begin errors++; $display("FAIL bp_release: got %h expected %h", di_o, exp_do); end
        cnt = free_count_o;
        drive(1'b1, 0, 0, 0, 1'b1);
        cycle();
        checks++; if (di_o.prd !== '0 || di_o.prd_old_valid !== 1'b0 || di_o.prs1_renammed !== 1'b0 || di_o.prs2_renammed !== 1'b0 || free_count_o !== cnt) begin
            errors++; $display("FAIL zero_reg: got %h count=%0d expected no alloc count=%0d", di_o, free_count_o, cnt); end
        drive(1'b1, 12, 11, 0, 1'b0);
        cycle();
        checks++; if (di_o.prd !== '0 || di_o.prs1_renammed !== 1'b1 || free_count_o !== cnt) begin
            errors++; $display("FAIL no_rd: got %h count=%0d expected no alloc count=%0d", di_o, free_count_o, cnt); end
        di_i_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        di_o_ready = 1'b1;
        drive(1'b1, 3, 0, 0, 1'b1);
        ret_none();
        cycle();
        checks++; if (di_o_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got %b expected 1", di_o_valid); end
        di_i_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (di_o_valid !== 1'b0 || di_o !== '0) begin
            errors++; $display("FAIL areset_immediate: got valid=%b di_o=%h expected 0 0", di_o_valid, di_o); end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++; if (free_count_o !== FL_FULL) begin errors++; $display("FAIL areset_count: got %0d expected 64", free_count_o); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            di_i = '0;
            di_i.si.rd = areg_id_t'($urandom_range(0, 7));
            di_i.si.rs1 = areg_id_t'($urandom_range(0, 7));
            di_i.si.rs2 = areg_id_t'($urandom_range(0, 7));
            di_i.si.rd_valid = $urandom_range(0, 4) != 0;
            di_i.si.rs1_valid = 1'($urandom);
            di_i.si.rs2_valid = 1'($urandom);
            di_i.id = ID_BITS'(n);
            di_i.valid = 1'b1;
            di_i_valid = $urandom_range(0, 3) != 0;
            di_o_ready = $urandom_range(0, 3) != 0;
            flush_i = $urandom_range(0, 63) == 0;
            if (rob.size() > 0 && $urandom_range(0, 2) == 0) ret_front();
            else if ($urandom_range(0, 7) == 0) begin
                r = $urandom;
                retire_entry_i = r[$bits(rob_entry_t)-1:0];
                retire_entry_i.needprf2arf = 1'b0;
                retire_entry_i_valid = 1'b1;
            end else ret_none();
            #1;
            checks++; if (di_i_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", n, di_i_ready, exp_ready()); end
            cycle();
            checks++; if (di_o_valid !== exp_ov) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", n, di_o_valid, exp_ov); end
            if (exp_ov) begin
                checks++; if (di_o !== exp_do) begin errors++; $display("FAIL rand_di_o@%0d: got %h expected %h", n, di_o, exp_do); end
            end
            checks++; if (free_count_o !== fl_ptr_t'(fq.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, free_count_o, fq.size()); end
        end
        flush_i = 1'b0;
        di_i_valid = 1'b0;
        ret_none();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_same_cycle();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
